// File: rtl/imem_arb_pkg.sv
// Shared encodings and constants for the instruction-memory arbiter.
package imem_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_F_ACT = 2'd1,
    ST_L_ACT = 2'd2
  } arb_state_e;

  localparam logic OWN_FETCH  = 1'b0;
  localparam logic OWN_LOADER = 1'b1;

  localparam logic [31:0] NOP_WORD_DFLT   = 32'h0000_0013;
  localparam logic [31:0] LOADER_ERR_WORD = 32'hFFFF_FFFF;

endpackage

// File: rtl/imem_arbiter_rr_pick2.sv
// Two-way round-robin picker: on a tie the requester that did not win last time is chosen.
module rr_pick2
  import imem_arb_pkg::*;
(
  input  logic [1:0] req_i,
  input  logic       last_i,
  output logic       grant_valid_o,
  output logic       grant_id_o
);

  // Tie goes to the non-last owner; otherwise whoever is asking.
  always_comb begin
    grant_valid_o = |req_i;
    if (req_i == 2'b11) begin
      grant_id_o = ~last_i;
    end else if (req_i[OWN_LOADER]) begin
      grant_id_o = OWN_LOADER;
    end else begin
      grant_id_o = OWN_FETCH;
    end
  end

endmodule

// File: rtl/imem_arbiter.sv
// Shares a single-port instruction memory between the fetch stage and a loader/debug port,
// with a busy-wait handshake, round-robin fairness and timeout abort.
module imem_arbiter
  import imem_arb_pkg::*;
#(
  parameter int          ADDR_W   = 10,
  parameter int          TIMEOUT  = 16,
  parameter logic [31:0] NOP_WORD = NOP_WORD_DFLT
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic              F_READ,
  input  logic [31:0]       F_ADDRESS,
  output logic [31:0]       F_READDATA,
  output logic              F_BUSYWAIT,
  input  logic              L_READ,
  input  logic              L_WRITE,
  input  logic [31:0]       L_ADDRESS,
  input  logic [31:0]       L_WRITEDATA,
  output logic [31:0]       L_READDATA,
  output logic              L_BUSYWAIT,
  output logic              MEM_READ,
  output logic              MEM_WRITE,
  output logic [ADDR_W-1:0] MEM_ADDRESS,
  output logic [31:0]       MEM_WRITEDATA,
  input  logic [31:0]       MEM_READDATA,
  input  logic              MEM_BUSYWAIT,
  output logic              TIMEOUT_ERR
);

  localparam int                CNT_W    = $clog2(TIMEOUT);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  arb_state_e        state_q, state_d;
  logic              last_grant_q, last_grant_d;
  logic [CNT_W-1:0]  wait_cnt_q, wait_cnt_d;
  logic              f_done_q, f_done_d;
  logic              l_done_q, l_done_d;
  logic              mem_read_q, mem_read_d;
  logic              mem_write_q, mem_write_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [31:0]       mem_wdata_q, mem_wdata_d;
  logic [31:0]       f_rdata_q, f_rdata_d;
  logic [31:0]       l_rdata_q, l_rdata_d;
  logic              timeout_err_q, timeout_err_d;

  logic              f_req_s, l_req_s;
  logic              pick_valid_s, pick_id_s;
  logic              unused_addr_s;

  assign f_req_s = F_READ;
  assign l_req_s = L_READ | L_WRITE;

  assign unused_addr_s = ^{F_ADDRESS[31:ADDR_W], F_ADDRESS[1:0],
                           L_ADDRESS[31:ADDR_W], L_ADDRESS[1:0]};

  // A requester in its done cycle is masked so a held request starts a fresh transaction.
  rr_pick2 u_pick (
    .req_i         ({l_req_s & ~l_done_q, f_req_s & ~f_done_q}),
    .last_i        (last_grant_q),
    .grant_valid_o (pick_valid_s),
    .grant_id_o    (pick_id_s)
  );

  always_comb begin
    state_d       = state_q;
    last_grant_d  = last_grant_q;
    wait_cnt_d    = wait_cnt_q;
    f_done_d      = 1'b0;
    l_done_d      = 1'b0;
    mem_read_d    = mem_read_q;
    mem_write_d   = mem_write_q;
    mem_addr_d    = mem_addr_q;
    mem_wdata_d   = mem_wdata_q;
    f_rdata_d     = f_rdata_q;
    l_rdata_d     = l_rdata_q;
    timeout_err_d = timeout_err_q;

    case (state_q)
      ST_IDLE: begin
        if (pick_valid_s) begin
          last_grant_d = pick_id_s;
          wait_cnt_d   = '0;
          if (pick_id_s == OWN_FETCH) begin
            state_d     = ST_F_ACT;
            mem_read_d  = 1'b1;
            mem_write_d = 1'b0;
            mem_addr_d  = {F_ADDRESS[ADDR_W-1:2], 2'b00};
          end else begin
            state_d     = ST_L_ACT;
            mem_read_d  = ~L_WRITE;
            mem_write_d = L_WRITE;
            mem_addr_d  = {L_ADDRESS[ADDR_W-1:2], 2'b00};
            mem_wdata_d = L_WRITEDATA;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end

      ST_F_ACT, ST_L_ACT: begin
        wait_cnt_d = wait_cnt_q + CNT_W'(1);
        if (!MEM_BUSYWAIT && (wait_cnt_q != '0)) begin
          state_d     = ST_IDLE;
          mem_read_d  = 1'b0;
          mem_write_d = 1'b0;
          if (state_q == ST_F_ACT) begin
            f_rdata_d = MEM_READDATA;
            f_done_d  = 1'b1;
          end else begin
            if (mem_read_q) begin
              l_rdata_d = MEM_READDATA;
            end else begin
              l_rdata_d = l_rdata_q;
            end
            l_done_d = 1'b1;
          end
        end else if (MEM_BUSYWAIT && (wait_cnt_q == CNT_LAST)) begin
          // Hung access: abort and hand back a harmless word.
          state_d       = ST_IDLE;
          mem_read_d    = 1'b0;
          mem_write_d   = 1'b0;
          timeout_err_d = 1'b1;
          if (state_q == ST_F_ACT) begin
            f_rdata_d = NOP_WORD;
            f_done_d  = 1'b1;
          end else begin
            if (mem_read_q) begin
              l_rdata_d = LOADER_ERR_WORD;
            end else begin
              l_rdata_d = l_rdata_q;
            end
            l_done_d = 1'b1;
          end
        end else begin
          state_d = state_q;
        end
      end

      default: begin
        state_d     = ST_IDLE;
        mem_read_d  = 1'b0;
        mem_write_d = 1'b0;
      end
    endcase
  end

  // State and registered outputs; reset drops the strobes immediately.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q       <= ST_IDLE;
      last_grant_q  <= OWN_LOADER;
      wait_cnt_q    <= '0;
      f_done_q      <= 1'b0;
      l_done_q      <= 1'b0;
      mem_read_q    <= 1'b0;
      mem_write_q   <= 1'b0;
      mem_addr_q    <= '0;
      mem_wdata_q   <= 32'h0000_0000;
      f_rdata_q     <= 32'h0000_0000;
      l_rdata_q     <= 32'h0000_0000;
      timeout_err_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      last_grant_q  <= last_grant_d;
      wait_cnt_q    <= wait_cnt_d;
      f_done_q      <= f_done_d;
      l_done_q      <= l_done_d;
      mem_read_q    <= mem_read_d;
      mem_write_q   <= mem_write_d;
      mem_addr_q    <= mem_addr_d;
      mem_wdata_q   <= mem_wdata_d;
      f_rdata_q     <= f_rdata_d;
      l_rdata_q     <= l_rdata_d;
      timeout_err_q <= timeout_err_d;
    end
  end

  assign F_BUSYWAIT    = f_req_s & ~f_done_q;
  assign L_BUSYWAIT    = l_req_s & ~l_done_q;
  assign F_READDATA    = f_rdata_q;
  assign L_READDATA    = l_rdata_q;
  assign MEM_READ      = mem_read_q;
  assign MEM_WRITE     = mem_write_q;
  assign MEM_ADDRESS   = mem_addr_q;
  assign MEM_WRITEDATA = mem_wdata_q;
  assign TIMEOUT_ERR   = timeout_err_q;

endmodule

// File: tb/tb_imem_arbiter.sv
// Bench for imem_arbiter: directed scenarios plus a randomized two-requester run against a word-level memory model.
module tb_imem_arbiter;

  logic        CLK = 1'b0;
  logic        RESET;
  logic        F_READ, L_READ, L_WRITE;
  logic [31:0] F_ADDRESS, L_ADDRESS, L_WRITEDATA;
  logic [31:0] F_READDATA, L_READDATA, MEM_WRITEDATA, MEM_READDATA;
  logic        F_BUSYWAIT, L_BUSYWAIT, MEM_READ, MEM_WRITE, MEM_BUSYWAIT, TIMEOUT_ERR;
  logic [9:0]  MEM_ADDRESS;

  int n_total = 0;
  int n_bad   = 0;

  logic [31:0] dev_mem [0:255];
  logic [31:0] ref_mem [0:255];
  int          busy_len = 1;
  bit          stuck = 1'b0;
  int          strobe_cnt;
  bit          prev_strobe = 1'b0;
  int          g_own [$];
  logic [31:0] g_addr [$];
  logic [31:0] g_wdata [$];

  always #5 CLK = ~CLK;

  imem_arbiter #(.ADDR_W(10), .TIMEOUT(16), .NOP_WORD(32'h0000_0013)) dut (
    .CLK(CLK), .RESET(RESET),
    .F_READ(F_READ), .F_ADDRESS(F_ADDRESS), .F_READDATA(F_READDATA), .F_BUSYWAIT(F_BUSYWAIT),
    .L_READ(L_READ), .L_WRITE(L_WRITE), .L_ADDRESS(L_ADDRESS), .L_WRITEDATA(L_WRITEDATA),
    .L_READDATA(L_READDATA), .L_BUSYWAIT(L_BUSYWAIT),
    .MEM_READ(MEM_READ), .MEM_WRITE(MEM_WRITE), .MEM_ADDRESS(MEM_ADDRESS),
    .MEM_WRITEDATA(MEM_WRITEDATA), .MEM_READDATA(MEM_READDATA), .MEM_BUSYWAIT(MEM_BUSYWAIT),
    .TIMEOUT_ERR(TIMEOUT_ERR)
  );

  // Memory device: busy for busy_len cycles of an access (or forever when stuck).
  assign MEM_BUSYWAIT = (MEM_READ | MEM_WRITE) & (stuck | (strobe_cnt < busy_len));
  assign MEM_READDATA = dev_mem[MEM_ADDRESS[9:2]];

  always @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      strobe_cnt <= 0;
    end else begin
      if (MEM_WRITE && !MEM_BUSYWAIT && strobe_cnt >= 1) dev_mem[MEM_ADDRESS[9:2]] = MEM_WRITEDATA;
      strobe_cnt <= (MEM_READ | MEM_WRITE) ? strobe_cnt + 1 : 0;
    end
  end

  // Grant monitor: log each new memory access (owner inferred from the strobe type).
  always @(negedge CLK) begin
    if ((MEM_READ | MEM_WRITE) && !prev_strobe) begin
      g_own.push_back(MEM_WRITE ? 1 : 0);
      g_addr.push_back({22'd0, MEM_ADDRESS});
      g_wdata.push_back(MEM_WRITEDATA);
    end
    prev_strobe = MEM_READ | MEM_WRITE;
  end

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic clear_log();
    g_own.delete(); g_addr.delete(); g_wdata.delete();
  endtask

  task automatic pulse_reset();
    @(negedge CLK); RESET = 1'b1;
    @(negedge CLK); RESET = 1'b0;
  endtask

  task automatic wait_f(input int limit, output int edges, output int rd_hi);
    edges = 0; rd_hi = 0;
    do begin
      @(negedge CLK); edges++;
      if (MEM_READ) rd_hi++;
    end while (F_BUSYWAIT && edges < limit);
  endtask

  task automatic wait_l(input int limit, output int edges);
    edges = 0;
    do begin
      @(negedge CLK); edges++;
    end while (L_BUSYWAIT && edges < limit);
  endtask

  task automatic drain();
    for (int i = 0; i < 60; i++) begin
      @(negedge CLK);
      if (!MEM_READ && !MEM_WRITE) break;
    end
    @(negedge CLK);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  int  e, rd;
  bit  f_fin, l_fin;
  int  f_idx, l_idx, l_op;
  logic [31:0] l_data;

  initial begin
    RESET = 1'b1; F_READ = 1'b0; L_READ = 1'b0; L_WRITE = 1'b0;
    F_ADDRESS = 32'd0; L_ADDRESS = 32'd0; L_WRITEDATA = 32'd0;
    for (int i = 0; i < 256; i++) dev_mem[i] = $urandom;

    // Reset state; stall follows the request while in reset.
    repeat (2) @(negedge CLK);
    check_eq("rst_mem_read", 32'(MEM_READ), 32'd0);
    check_eq("rst_mem_write", 32'(MEM_WRITE), 32'd0);
    check_eq("rst_mem_addr", 32'(MEM_ADDRESS), 32'd0);
    check_eq("rst_mem_wdata", MEM_WRITEDATA, 32'd0);
    check_eq("rst_f_rdata", F_READDATA, 32'd0);
    check_eq("rst_l_rdata", L_READDATA, 32'd0);
    check_eq("rst_timeout_err", 32'(TIMEOUT_ERR), 32'd0);
    F_READ = 1'b1; #1;
    check_eq("rst_f_busy_follows", 32'(F_BUSYWAIT), 32'd1);
    F_READ = 1'b0;
    @(negedge CLK); RESET = 1'b0;

    // Single fetch with a 1-cycle-busy memory.
    busy_len = 1; dev_mem[2] = 32'h0020_8333; clear_log();
    F_READ = 1'b1; F_ADDRESS = 32'h8;
    wait_f(40, e, rd); F_READ = 1'b0;
    check_eq("t1_edges", 32'(e), 32'd3);
    check_eq("t1_read_cycles", 32'(rd), 32'd2);
    check_eq("t1_rdata", F_READDATA, 32'h0020_8333);
    check_eq("t1_ngrants", 32'(g_own.size()), 32'd1);
    check_eq("t1_mem_addr", g_addr[0], 32'h8);

    // Simultaneous fetch and loader write: fetch first, then the write.
    pulse_reset(); clear_log(); dev_mem[4] = 32'd0;
    F_READ = 1'b1; F_ADDRESS = 32'h4;
    L_WRITE = 1'b1; L_ADDRESS = 32'h10; L_WRITEDATA = 32'hDEAD_BEEF;
    e = 0;
    do begin
      @(negedge CLK); e++;
      if (!F_BUSYWAIT) F_READ = 1'b0;
    end while (L_BUSYWAIT && e < 40);
    L_WRITE = 1'b0;
    check_eq("t2_l_edges", 32'(e), 32'd6);
    check_eq("t2_ngrants", 32'(g_own.size()), 32'd2);
    check_eq("t2_first_owner", 32'(g_own[0]), 32'd0);
    check_eq("t2_second_owner", 32'(g_own[1]), 32'd1);
    check_eq("t2_write_addr", g_addr[1], 32'h10);
    check_eq("t2_write_data", g_wdata[1], 32'hDEAD_BEEF);
    check_eq("t2_mem_written", dev_mem[4], 32'hDEAD_BEEF);
    drain();

    // Both held: grants must alternate F, L, F, L ...
    pulse_reset(); busy_len = 2; clear_log();
    F_READ = 1'b1; F_ADDRESS = 32'h40;
    L_WRITE = 1'b1; L_ADDRESS = 32'h300; L_WRITEDATA = 32'h5A5A_0001;
    e = 0;
    while (g_own.size() < 8 && e < 300) begin @(negedge CLK); e++; end
    F_READ = 1'b0; L_WRITE = 1'b0;
    drain();
    check_eq("t3_ngrants", 32'(g_own.size()), 32'd8);
    for (int i = 0; i < 8; i++) check_eq($sformatf("t3_owner_%0d", i), 32'(g_own[i]), 32'(i % 2));

    // Stuck memory: fetch aborts with a NOP and the sticky flag.
    stuck = 1'b1; clear_log();
    F_READ = 1'b1; F_ADDRESS = 32'h0;
    wait_f(60, e, rd); F_READ = 1'b0;
    check_eq("t4_abort_edges", 32'(e), 32'd17);
    check_eq("t4_read_cycles", 32'(rd), 32'd16);
    check_eq("t4_nop", F_READDATA, 32'h0000_0013);
    check_eq("t4_err_set", 32'(TIMEOUT_ERR), 32'd1);
    stuck = 1'b0; busy_len = 1;
    @(negedge CLK);
    F_READ = 1'b1; F_ADDRESS = 32'h8;
    wait_f(40, e, rd); F_READ = 1'b0;
    check_eq("t4_good_read", F_READDATA, 32'h0020_8333);
    check_eq("t4_err_sticky", 32'(TIMEOUT_ERR), 32'd1);
    stuck = 1'b1;
    L_READ = 1'b1; L_ADDRESS = 32'h204;
    wait_l(60, e); L_READ = 1'b0;
    check_eq("t4_l_abort_edges", 32'(e), 32'd17);
    check_eq("t4_l_err_word", L_READDATA, 32'hFFFF_FFFF);
    stuck = 1'b0;
    drain();

    // Reset during a loader write: strobe drops at once, write re-issues afterwards.
    pulse_reset();
    check_eq("t5_err_cleared", 32'(TIMEOUT_ERR), 32'd0);
    busy_len = 3; dev_mem[8] = 32'd0;
    L_WRITE = 1'b1; L_ADDRESS = 32'h20; L_WRITEDATA = 32'h1234_5678;
    e = 0;
    do begin @(negedge CLK); e++; end while (!MEM_WRITE && e < 10);
    #2 RESET = 1'b1;
    #1;
    check_eq("t5_async_strobe", 32'(MEM_WRITE), 32'd0);
    check_eq("t5_async_addr", 32'(MEM_ADDRESS), 32'd0);
    check_eq("t5_busy_in_reset", 32'(L_BUSYWAIT), 32'd1);
    @(negedge CLK); RESET = 1'b0;
    check_eq("t5_write_lost", dev_mem[8], 32'd0);
    wait_l(40, e); L_WRITE = 1'b0;
    check_eq("t5_reissue_edges", 32'(e), 32'd5);
    check_eq("t5_write_done", dev_mem[8], 32'h1234_5678);

    // Address folding: only bits [9:2] reach the memory.
    busy_len = 1; dev_mem[3] = 32'hCAFE_0013; clear_log();
    @(negedge CLK);
    F_READ = 1'b1; F_ADDRESS = 32'hFFFF_F40F;
    wait_f(40, e, rd); F_READ = 1'b0;
    check_eq("t6_ngrants", 32'(g_own.size()), 32'd1);
    check_eq("t6_mem_addr", g_addr[0], 32'h0000_000C);
    check_eq("t6_rdata", F_READDATA, 32'hCAFE_0013);
    drain();

    // Randomized: fetch reads the low half, loader reads/writes the high half.
    for (int i = 0; i < 256; i++) ref_mem[i] = dev_mem[i];
    f_fin = 1'b0; l_fin = 1'b0;
    fork
      begin : fetch_thr
        for (int t = 0; t < 40; t++) begin
          f_idx = $urandom_range(0, 127);
          F_ADDRESS = ($urandom & 32'hFFFF_FC00) | (32'(f_idx) << 2) | 32'($urandom_range(0, 3));
          F_READ = 1'b1;
          wait_f(100, e, rd);
          check_eq("rnd_f_complete", 32'(F_BUSYWAIT), 32'd0);
          check_eq("rnd_f_data", F_READDATA, ref_mem[f_idx]);
          F_READ = 1'b0;
          repeat ($urandom_range(0, 2)) @(negedge CLK);
        end
        f_fin = 1'b1;
      end
      begin : loader_thr
        int le;
        for (int t = 0; t < 40; t++) begin
          l_idx = $urandom_range(128, 255);
          l_op = $urandom_range(0, 2);
          l_data = $urandom;
          L_ADDRESS = ($urandom & 32'hFFFF_FC00) | (32'(l_idx) << 2) | 32'($urandom_range(0, 3));
          L_WRITEDATA = l_data;
          L_READ = (l_op != 1);
          L_WRITE = (l_op != 0);
          if (l_op != 0) ref_mem[l_idx] = l_data;
          le = 0;
          do begin @(negedge CLK); le++; end while (L_BUSYWAIT && le < 100);
          check_eq("rnd_l_complete", 32'(L_BUSYWAIT), 32'd0);
          if (l_op == 0) check_eq("rnd_l_rdata", L_READDATA, ref_mem[l_idx]);
          else check_eq("rnd_l_written", dev_mem[l_idx], ref_mem[l_idx]);
          L_READ = 1'b0; L_WRITE = 1'b0;
          repeat ($urandom_range(0, 2)) @(negedge CLK);
        end
        l_fin = 1'b1;
      end
      begin : busy_thr
        while (!(f_fin && l_fin)) begin
          @(negedge CLK);
          busy_len = $urandom_range(0, 3);
        end
      end
    join
    drain();
    check_eq("rnd_no_timeout", 32'(TIMEOUT_ERR), 32'd0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

// File: doc/imem_arbiter.md
Name: imem_arbiter

Overview:
- Shares the single-port instruction memory between two requesters: the CPU fetch stage (read-only) and a program loader/debug port (read/write).
- Sequences each memory transaction with a BUSYWAIT handshake and applies round-robin fairness under contention.
- Aborts transactions that hang and flags them.
- Sits between the IF stage / loader and the instruction memory.

Parameters:
- ADDR_W, 10, memory-side byte-address width; upper requester address bits are dropped.
- TIMEOUT, 16, maximum number of memory-busy cycles before abort (must be ≥2).
- NOP_WORD, 32'h00000013, word returned to fetch on a timed-out read.

Ports:
- CLK  in  1  system clock, rising edge.
- RESET  in  1  asynchronous, active-high reset.
- F_READ  in  1  fetch read request (level).
- F_ADDRESS  in  32  fetch byte address.
- F_READDATA  out  32  fetched instruction word.
- F_BUSYWAIT  out  1  fetch stall.
- L_READ  in  1  loader read request.
- L_WRITE  in  1  loader write request.
- L_ADDRESS  in  32  loader byte address.
- L_WRITEDATA  in  32  loader write word.
- L_READDATA  out  32  loader read word.
- L_BUSYWAIT  out  1  loader stall.
- MEM_READ  out  1  memory read strobe.
- MEM_WRITE  out  1  memory write strobe.
- MEM_ADDRESS  out  ADDR_W  word-aligned memory address.
- MEM_WRITEDATA  out  32  memory write word.
- MEM_READDATA  in  32  memory read word.
- MEM_BUSYWAIT  in  1  memory busy.
- TIMEOUT_ERR  out  1  sticky timeout flag.

Behaviour:
- One clock domain. RESET is asynchronous and active-high; the clock and reset ports are named CLK and RESET.
- Reset values:
  - state = IDLE; MEM_READ = MEM_WRITE = 0.
  - MEM_ADDRESS, MEM_WRITEDATA, F_READDATA, L_READDATA = 0.
  - TIMEOUT_ERR = 0; last_grant = LOADER, so fetch wins the first tie; done flags = 0; wait_cnt = 0.
- Requests:
  - f_req = F_READ.
  - l_req = L_READ | L_WRITE. If both L_READ and L_WRITE are set, the transaction is a write.
- Requester stalls are combinational:
  - F_BUSYWAIT = f_req & ~f_done.
  - L_BUSYWAIT = l_req & ~l_done.
  - During reset, BUSYWAIT follows the request directly.
- State machine:
  - IDLE → F_ACT or L_ACT at the edge where a request is seen.
    - Under contention, grant the requester not equal to last_grant; otherwise grant whichever requester is active.
    - On grant: register MEM_ADDRESS = {ADDR[ADDR_W-1:2], 2'b00}, MEM_WRITEDATA, and the MEM_READ/MEM_WRITE strobe; update last_grant; clear wait_cnt.
  - F_ACT / L_ACT hold the strobes and increment wait_cnt on each edge.
    - Completion edge: wait_cnt ≥ 1 and MEM_BUSYWAIT = 0.
    - On completion: drop the strobes, capture MEM_READDATA into the owner's READDATA (reads only), set the owner's done flag, and return to IDLE.
    - Timeout edge: wait_cnt = TIMEOUT-1 with MEM_BUSYWAIT still 1. Drop the strobes, set TIMEOUT_ERR, and load F_READDATA = NOP_WORD (fetch) or L_READDATA = 32'hFFFFFFFF (loader read). Set the done flag and return to IDLE.
- Done flags:
  - Each done flag is a one-cycle pulse, cleared at the next edge.
  - The done cycle is never a grant cycle for that requester, so a request held high re-issues one cycle later as a new transaction.
  - The other requester may be granted in that same IDLE cycle.
- Latency: the minimum transaction is 3 edges from request to BUSYWAIT low (grant, complete, then done visible).
- A request withdrawn while active does not cancel the memory access; the result is captured and discarded, and done is set with no effect.
- Readdata registers hold their value until the next completion for that owner.
- TIMEOUT_ERR clears only on RESET.
- A RESET asserted mid-transaction immediately drops the strobes; the in-flight transaction is lost, and the requester re-issues after reset.
- Address bits [1:0] are ignored; there is no misalignment fault.

Decomposition:
- A shared package `imem_arb_pkg` holds:
  - the state encoding (IDLE, F_ACT, L_ACT);
  - the owner encoding (FETCH = 0, LOADER = 1);
  - the NOP_WORD default.
- One natural sub-module, `rr_pick2`: a two-way round-robin picker (inputs req[1:0] and last; outputs grant_valid and grant_id), purely combinational.
- The FSM, counter and registers stay in imem_arbiter.

Test Plan:
- Memory with 1-cycle busy; F_READ=1, F_ADDRESS=0x8, memory word 0x00208333:
  - F_BUSYWAIT falls on the 3rd edge with F_READDATA=0x00208333.
  - MEM_ADDRESS=0x8; MEM_READ is high for exactly 2 cycles.
- F_READ and L_WRITE(addr 0x10, data 0xDEADBEEF) rise together after reset:
  - Fetch is granted first, then the loader write.
  - MEM_WRITE is asserted with MEM_ADDRESS=0x10 and MEM_WRITEDATA=0xDEADBEEF.
  - L_BUSYWAIT stays high until that write completes.
- Both requests held continuously for 8 transactions:
  - Grants alternate F, L, F, L...; neither requester waits more than one transaction.
- MEM_BUSYWAIT stuck at 1 with F_READ, TIMEOUT=16:
  - Abort after 15 active edges; F_READDATA=0x00000013 and TIMEOUT_ERR=1.
  - TIMEOUT_ERR is still 1 after a subsequent good read.
- RESET pulsed while in L_ACT:
  - MEM_WRITE goes low asynchronously and state returns to IDLE.
  - After release, the held L_WRITE re-issues and completes normally.
- F_ADDRESS=0xFFFF_F40F with ADDR_W=10:
  - MEM_ADDRESS=0x00C; the low bits and upper bits are dropped.
